test_logic: RTL and testbench

Clocked three-input logic evaluator. Each cycle it samples inputs A, B, C and registers two Boolean functions of them: F, the odd-parity (sum) bit, and G, the majority (carry) bit. It also records which of the eight input combinations it has sampled since the last clear, so a bench or on-chip monitor can confirm exhaustive truth-table coverage. It is a leaf block in the teaching and bring-up datapath, driven directly from switches or bench stimulus.

---
 rtl/test_logic_pkg.sv | 13 +
 rtl/test_logic_cell.sv | 17 +
 rtl/test_logic.sv | 36 +++
 tb/tb_test_logic.sv | 112 +++++++++++
 4 files changed

// File: rtl/test_logic_pkg.sv
// test_logic_pkg: shared widths, Boolean helpers and truth-table vectors for test_logic.
package test_logic_pkg;
  localparam int IDX_W = 3;
  localparam int NCOMB = 8;
  localparam logic [NCOMB-1:0] F_TT = 8'b1001_0110;
  localparam logic [NCOMB-1:0] G_TT = 8'b1110_1000;
  function automatic logic f_parity(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction
  function automatic logic f_major(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/test_logic_cell.sv
// logic_cell: combinational sum/carry next-state for the three operand bits.
module logic_cell
  import test_logic_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f,
  output logic g
);
  logic [IDX_W-1:0] idx;
  assign idx = {a, b, c};
  assign f = f_parity(a, b, c);
  assign g = f_major(a, b, c);
  // the closed-form functions must agree with the tabulated truth table
  always_comb assert (f == F_TT[idx] && g == G_TT[idx]);
endmodule

// File: rtl/test_logic.sv
// test_logic: registered parity/majority of A,B,C plus input-combination coverage tracking.
module test_logic
  import test_logic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             clr,
  output logic             F,
  output logic             G,
  output logic [NCOMB-1:0] cov,
  output logic             all_seen
);
  logic             f_nx;
  logic             g_nx;
  logic [IDX_W-1:0] idx;
  logic [NCOMB-1:0] cov_nx;
  assign idx = {A, B, C};
  logic_cell u_cell (.a(A), .b(B), .c(C), .f(f_nx), .g(g_nx));
  // clr wins over the sample taken in the same cycle
  assign cov_nx = clr ? '0 : cov | (NCOMB'(1) << idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      F        <= 1'b0;
      G        <= 1'b0;
      cov      <= '0;
      all_seen <= 1'b0;
    end else begin
      F        <= f_nx;
      G        <= g_nx;
      cov      <= cov_nx;
      all_seen <= &cov_nx;
    end
endmodule

// File: tb/tb_test_logic.sv
// tb_test_logic: directed self-checking bench for test_logic.
module tb_test_logic;
  import test_logic_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b1, B = 1'b1, C = 1'b1, clr = 1'b0;
  logic       F, G, all_seen;
  logic [7:0] cov;
  int         checks = 0;
  int         errors = 0;

  test_logic dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .clr(clr),
                  .F(F), .G(G), .cov(cov), .all_seen(all_seen));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic c);
    {A, B, C} = 3'(idx);
    clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_F", F, 0);
    check("rst_G", G, 0);
    check("rst_cov", cov, 8'h00);
    check("rst_all", all_seen, 0);
    rst_n = 1'b1;
    drive(7, 0);
    check("rel_F", F, 1);
    check("rel_G", G, 1);
    check("rel_cov", cov, 8'h80);
    check("rel_all", all_seen, 0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    check("pulse_cov", cov, 8'h00);
    for (int i = 0; i < 8; i++) begin
      drive(i, 0);
      check($sformatf("sweep_F%0d", i), F, F_TT[i]);
      check($sformatf("sweep_G%0d", i), G, G_TT[i]);
      if (i == 6) begin
        check("sweep_cov6", cov, 8'h7F);
        check("sweep_all6", all_seen, 0);
      end
    end
    check("sweep_cov", cov, 8'hFF);
    check("sweep_all", all_seen, 1);
    drive(2, 1);
    check("clr_cov", cov, 8'h00);
    check("clr_all", all_seen, 0);
    check("clr_F", F, 1);
    check("clr_G", G, 0);
    drive(2, 0);
    check("post_clr_cov", cov, 8'h04);
    drive(0, 1);
    drive(3, 0);
    check("part_cov3", cov, 8'h08);
    drive(3, 0);
    check("part_cov33", cov, 8'h08);
    drive(5, 0);
    check("part_cov", cov, 8'h28);
    check("part_all", all_seen, 0);
    drive(3, 0);
    check("part_idem", cov, 8'h28);
    drive(0, 1);
    for (int i = 0; i < 5; i++) drive(i, 0);
    check("mid_cov", cov, 8'h1F);
    check("mid_F", F, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_cov", cov, 8'h00);
    check("async_F", F, 0);
    check("async_G", G, 0);
    check("async_all", all_seen, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_cov", cov, 8'h10);
    check("restart_F", F, 1);
    @(posedge clk);
    #1 {A, B, C} = 3'd3;
    #1;
    check("lat_F_hold", F, 1);
    check("lat_G_hold", G, 0);
    check("lat_cov_hold", cov, 8'h10);
    @(negedge clk);
    check("lat_F_neg", F, 1);
    @(posedge clk);
    @(negedge clk);
    check("lat_F", F, 0);
    check("lat_G", G, 1);
    check("lat_cov", cov, 8'h18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
